saph_rast_multilane: RTL and testbench
======================================

Name: saph_rast_multilane

Overview:
- Parametrised successor to the single-pixel primitive rasterizer.
- Takes one triangle or rectangle and walks its scissor-clipped bounding box row-major.
- Emits groups of LANES horizontally adjacent pixels per beat, each beat carrying a per-lane coverage mask.
- Sits between primitive setup and the shading/plot stage.

Parameters:
- COORD_W, 12, signed integer coordinate width in bits.
- LANES, 4, pixels per output beat (power of two, 1..16).
- SKIP_EMPTY, 1, suppress beats whose mask is all zero.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_trig  in  1  start primitive; accepted only when in_ready=1
- in_type  in  2  0 reserved, 1 line, 2 triangle, 3 rectangle
- in_x  in  3×COORD_W signed  vertex x (rectangle uses v0, v1)
- in_y  in  3×COORD_W signed  vertex y
- clip_x0, clip_y0, clip_x1, clip_y1  in  COORD_W signed each  inclusive scissor, sampled at accept
- in_ready  out  1  idle, can accept next cycle
- out_trig  out  1  beat valid
- out_x  out  COORD_W  x of lane 0
- out_y  out  COORD_W  row
- out_mask  out  LANES  bit l covers pixel (out_x+l, out_y)
- out_ready  in  1  consumer accepts beat this cycle
- out_done  out  1  one-cycle pulse: primitive finished

Behaviour:
- Reset values: in_ready=1, out_trig=0, out_done=0, out_x/out_y/out_mask=0. FSM returns to IDLE and discards any primitive in flight, including mid-SCAN.
- FSM states: IDLE, SETUP, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - in_trig captures vertices, type and clip → SETUP.
- SETUP (1 cycle):
  - Bounding box:
    - Triangle: min/max of v0..v2.
    - Rectangle: min/max of v0, v1, inclusive.
    - Intersect the result with the clip window.
  - Triangle only: compute edge coefficients.
  - Empty box, type 0/1, or zero-area triangle → DONE.
  - Otherwise → SCAN with cursor (bxmin, bymin).
- SCAN:
  - Each beat covers x = cursor..cursor+LANES-1.
  - Lane valid iff x ≤ bxmax and inside the shape.
  - Rectangle: every lane in the box is inside.
  - Triangle edge function: E_i = (x−xa)(yb−ya) − (y−ya)(xb−xa) for edges (0,1), (1,2), (2,0).
    - Pixel inside iff all three E ≥ 0, or all three E ≤ 0 (winding-agnostic, edges inclusive).
  - Arithmetic: signed, at least 2·COORD_W+2 bits, no overflow for any COORD_W-range input. Incremental stepping is allowed if results are identical.
  - Cursor advance:
    - Advances by LANES when the beat is accepted (out_trig & out_ready), or immediately when the mask is zero and SKIP_EMPTY=1.
    - Past bxmax → cursor x=bxmin, y+1.
    - Past bymax → DONE.
  - Zero-mask skip costs one cycle per group.
- Output handshake:
  - Beat is registered.
  - While out_trig=1 and out_ready=0, out_x/out_y/out_mask hold stable.
  - Back-to-back beats sustain 1 beat/cycle with out_ready=1.
- DONE (1 cycle):
  - out_done=1 → IDLE.
  - in_ready rises the following cycle.
  - Latency from accept to first beat: 2 cycles (SETUP, then registered beat).
- Boundaries:
  - Single-pixel primitive → one beat, mask bit0 only.
  - Box narrower than LANES → upper lanes masked off.
  - Clip fully outside → no beats, out_done.
  - in_trig while busy is ignored.
  - Coordinates are two's-complement; negative boxes are legal.

Decomposition:
- saph_defines gets:
  - SAPH_PRIM_LINE/TRI/RECT type constants.
  - typedef saph_rast_state_e.
- One sub-module: saph_rast_edge, which evaluates one edge function for LANES consecutive x (combinational, signed-width parameter). Instantiated 3×.

Test Plan:
- LANES=4. Rect (2,1)-(5,2), clip (0,0)-(100,100), out_ready=1 → beats (2,1,1111), (2,2,1111), then out_done. First beat 2 cycles after accept.
- LANES=4. Tri (0,0),(3,0),(0,3) → beats (0,0,1111), (0,1,0111), (0,2,0011), (0,3,0001). Same output with vertex order reversed.
- Same triangle with clip (1,1)-(2,2) → (1,1,0011), (1,2,0001). Clip (10,10)-(20,20) → no beats, out_done only.
- Degenerate tri (0,0),(2,2),(4,4), and in_type=1 → no beats, out_done, in_ready back within 3 cycles.
- Rect (0,0)-(7,0) with out_ready low for 3 cycles on beat 1 → (0,0,1111) held stable, then (4,0,1111); no duplicate or lost beat.
- rst asserted mid-SCAN of a 16×16 rect → next cycle out_trig=0, in_ready=1; a new rect then rasterizes correctly.

Source files
------------

// File: rtl/saph_defines.sv
// rtl/saph_defines.sv - primitive type codes and rasterizer FSM state encoding
package saph_defines;

   localparam logic [1:0] SAPH_PRIM_LINE = 2'd1;
   localparam logic [1:0] SAPH_PRIM_TRI  = 2'd2;
   localparam logic [1:0] SAPH_PRIM_RECT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_SCAN  = 2'd2,
      S_DONE  = 2'd3
   } saph_rast_state_e;

endpackage

// File: rtl/saph_rast_edge.sv
// rtl/saph_rast_edge.sv - one triangle edge function evaluated for LANES consecutive x
module saph_rast_edge #(
   parameter int COORD_W = 12,
   parameter int LANES   = 4,
   parameter int W       = 2*COORD_W + 6
) (
   input  logic signed [COORD_W-1:0] x_i,
   input  logic signed [COORD_W-1:0] y_i,
   input  logic signed [COORD_W-1:0] xa_i,
   input  logic signed [COORD_W-1:0] ya_i,
   input  logic signed [COORD_W:0]   dx_i,
   input  logic signed [COORD_W:0]   dy_i,
   output logic [LANES-1:0]          ge_o,
   output logic [LANES-1:0]          le_o
);

   logic signed [W-1:0] row_c;
   logic signed [W-1:0] e_c [LANES];

   // The y term is shared by every lane of the beat; only the x term varies.
   always_comb begin
      row_c = (W'(y_i) - W'(ya_i)) * W'(dx_i);
      ge_o  = '0;
      le_o  = '0;
      for (int l = 0; l < LANES; l++) begin
         e_c[l]  = (W'(x_i) + W'(l) - W'(xa_i)) * W'(dy_i) - row_c;
         ge_o[l] = !e_c[l][W-1];
         le_o[l] = e_c[l][W-1] || (e_c[l] == '0);
      end
   end

endmodule

// File: rtl/saph_rast_multilane.sv
// rtl/saph_rast_multilane.sv - scissored triangle/rectangle rasterizer emitting LANES-wide masked beats
module saph_rast_multilane
   import saph_defines::*;
#(
   parameter int COORD_W    = 12,
   parameter int LANES      = 4,
   parameter int SKIP_EMPTY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_trig,
   input  logic [1:0]             in_type,
   input  logic [3*COORD_W-1:0]   in_x,
   input  logic [3*COORD_W-1:0]   in_y,
   input  logic [COORD_W-1:0]     clip_x0,
   input  logic [COORD_W-1:0]     clip_y0,
   input  logic [COORD_W-1:0]     clip_x1,
   input  logic [COORD_W-1:0]     clip_y1,
   output logic                   in_ready,
   output logic                   out_trig,
   output logic [COORD_W-1:0]     out_x,
   output logic [COORD_W-1:0]     out_y,
   output logic [LANES-1:0]       out_mask,
   input  logic                   out_ready,
   output logic                   out_done
);

   localparam int W  = 2*COORD_W + 6;
   localparam int XW = COORD_W + 2;

   saph_rast_state_e          state_q;
   logic [1:0]                type_q;
   logic signed [COORD_W-1:0] vx_q [3];
   logic signed [COORD_W-1:0] vy_q [3];
   logic signed [COORD_W-1:0] cx0_q, cy0_q, cx1_q, cy1_q;
   logic signed [COORD_W-1:0] bx0_q, by0_q, bx1_q, by1_q;
   logic signed [COORD_W-1:0] cur_x_q, cur_y_q;
   logic signed [COORD_W:0]   edx_q [3];
   logic signed [COORD_W:0]   edy_q [3];
   logic                      fin_q, in_ready_q, out_trig_q, out_done_q;
   logic [COORD_W-1:0]        out_x_q, out_y_q;
   logic [LANES-1:0]          out_mask_q;

   logic signed [COORD_W-1:0] mnx, mxx, mny, mxy;
   logic signed [COORD_W-1:0] bx0_d, bx1_d, by0_d, by1_d;
   logic signed [W-1:0]       area_c;
   logic                      go_scan;

   always_comb begin
      mnx = (vx_q[0] < vx_q[1]) ? vx_q[0] : vx_q[1];
      mxx = (vx_q[0] < vx_q[1]) ? vx_q[1] : vx_q[0];
      mny = (vy_q[0] < vy_q[1]) ? vy_q[0] : vy_q[1];
      mxy = (vy_q[0] < vy_q[1]) ? vy_q[1] : vy_q[0];
      if (type_q == SAPH_PRIM_TRI) begin
         if (vx_q[2] < mnx) mnx = vx_q[2];
         if (vx_q[2] > mxx) mxx = vx_q[2];
         if (vy_q[2] < mny) mny = vy_q[2];
         if (vy_q[2] > mxy) mxy = vy_q[2];
      end
      bx0_d = (mnx > cx0_q) ? mnx : cx0_q;
      bx1_d = (mxx < cx1_q) ? mxx : cx1_q;
      by0_d = (mny > cy0_q) ? mny : cy0_q;
      by1_d = (mxy < cy1_q) ? mxy : cy1_q;
      area_c = (W'(vx_q[1]) - W'(vx_q[0])) * (W'(vy_q[2]) - W'(vy_q[0]))
             - (W'(vy_q[1]) - W'(vy_q[0])) * (W'(vx_q[2]) - W'(vx_q[0]));
      go_scan = (bx0_d <= bx1_d) && (by0_d <= by1_d) &&
                ((type_q == SAPH_PRIM_RECT) || ((type_q == SAPH_PRIM_TRI) && (area_c != '0)));
   end

   logic [LANES-1:0] ge [3];
   logic [LANES-1:0] le [3];

   for (genvar e = 0; e < 3; e++) begin : g_edge
      saph_rast_edge #(.COORD_W(COORD_W), .LANES(LANES), .W(W)) u_edge (
         .x_i  (cur_x_q),
         .y_i  (cur_y_q),
         .xa_i (vx_q[e]),
         .ya_i (vy_q[e]),
         .dx_i (edx_q[e]),
         .dy_i (edy_q[e]),
         .ge_o (ge[e]),
         .le_o (le[e])
      );
   end

   logic [LANES-1:0]     mask_c;
   logic signed [XW-1:0] lx_c, nx_c;
   logic                 wrap_c, last_row_c, free_c, emit_c;

   // Cursor arithmetic is widened so a group straddling the top of the coordinate range cannot wrap.
   always_comb begin
      mask_c = '0;
      lx_c   = '0;
      for (int l = 0; l < LANES; l++) begin
         lx_c = XW'(cur_x_q) + XW'(l);
         if (lx_c <= XW'(bx1_q))
            mask_c[l] = (type_q == SAPH_PRIM_RECT) ||
                        (ge[0][l] && ge[1][l] && ge[2][l]) ||
                        (le[0][l] && le[1][l] && le[2][l]);
      end
      nx_c       = XW'(cur_x_q) + XW'(LANES);
      wrap_c     = nx_c > XW'(bx1_q);
      last_row_c = (cur_y_q == by1_q);
      free_c     = !out_trig_q || out_ready;
      emit_c     = (mask_c != '0) || (SKIP_EMPTY == 0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         in_ready_q <= 1'b1;
         out_trig_q <= 1'b0;
         out_done_q <= 1'b0;
         out_x_q    <= '0;
         out_y_q    <= '0;
         out_mask_q <= '0;
         fin_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_trig) begin
                  type_q <= in_type;
                  for (int i = 0; i < 3; i++) begin
                     vx_q[i] <= in_x[i*COORD_W +: COORD_W];
                     vy_q[i] <= in_y[i*COORD_W +: COORD_W];
                  end
                  cx0_q      <= clip_x0;
                  cy0_q      <= clip_y0;
                  cx1_q      <= clip_x1;
                  cy1_q      <= clip_y1;
                  in_ready_q <= 1'b0;
                  state_q    <= S_SETUP;
               end
            end
            S_SETUP: begin
               bx0_q   <= bx0_d;
               bx1_q   <= bx1_d;
               by0_q   <= by0_d;
               by1_q   <= by1_d;
               cur_x_q <= bx0_d;
               cur_y_q <= by0_d;
               fin_q   <= 1'b0;
               for (int i = 0; i < 3; i++) begin
                  edx_q[i] <= (COORD_W+1)'(vx_q[(i+1)%3]) - (COORD_W+1)'(vx_q[i]);
                  edy_q[i] <= (COORD_W+1)'(vy_q[(i+1)%3]) - (COORD_W+1)'(vy_q[i]);
               end
               if (go_scan) begin
                  state_q <= S_SCAN;
               end else begin
                  state_q    <= S_DONE;
                  out_done_q <= 1'b1;
               end
            end
            S_SCAN: begin
               // After the last group is issued, wait for the output slot to drain before finishing.
               if (fin_q) begin
                  if (free_c) begin
                     out_trig_q <= 1'b0;
                     out_done_q <= 1'b1;
                     state_q    <= S_DONE;
                  end
               end else begin
                  if (free_c) out_trig_q <= 1'b0;
                  if (free_c && emit_c) begin
                     out_trig_q <= 1'b1;
                     out_x_q    <= cur_x_q;
                     out_y_q    <= cur_y_q;
                     out_mask_q <= mask_c;
                  end
                  if (!emit_c || free_c) begin
                     if (wrap_c) begin
                        cur_x_q <= bx0_q;
                        if (last_row_c) fin_q <= 1'b1;
                        else cur_y_q <= cur_y_q + COORD_W'(1);
                     end else begin
                        cur_x_q <= nx_c[COORD_W-1:0];
                     end
                  end
               end
            end
            S_DONE: begin
               out_done_q <= 1'b0;
               in_ready_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign out_trig = out_trig_q;
   assign out_x    = out_x_q;
   assign out_y    = out_y_q;
   assign out_mask = out_mask_q;
   assign out_done = out_done_q;

endmodule

// File: tb/tb_saph_rast_multilane.sv
// tb/tb_saph_rast_multilane.sv - directed and randomized bench for saph_rast_multilane
module tb_saph_rast_multilane;

   localparam int CW = 12;
   localparam int LN = 4;

   logic              clk = 1'b0;
   logic              rst, in_trig, out_ready;
   logic [1:0]        in_type;
   logic [3*CW-1:0]   in_x, in_y;
   logic [CW-1:0]     clip_x0, clip_y0, clip_x1, clip_y1;
   logic              in_ready, out_trig, out_done;
   logic [CW-1:0]     out_x, out_y;
   logic [LN-1:0]     out_mask;

   always #5 clk = ~clk;

   saph_rast_multilane #(.COORD_W(CW), .LANES(LN), .SKIP_EMPTY(1)) dut (
      .clk(clk), .rst(rst), .in_trig(in_trig), .in_type(in_type),
      .in_x(in_x), .in_y(in_y),
      .clip_x0(clip_x0), .clip_y0(clip_y0), .clip_x1(clip_x1), .clip_y1(clip_y1),
      .in_ready(in_ready), .out_trig(out_trig), .out_x(out_x), .out_y(out_y),
      .out_mask(out_mask), .out_ready(out_ready), .out_done(out_done)
   );

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [LN-1:0] m;
   } beat_t;

   beat_t      exp_q[$];
   beat_t      got_q[$];
   int         checks = 0;
   int         errors = 0;
   int         px[3], py[3], cl[4];
   logic [1:0] pt;
   int         first_idx;
   logic       done_seen;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint edge_v(int xa, int ya, int xb, int yb, int x, int y);
      return longint'(x - xa) * longint'(yb - ya) - longint'(y - ya) * longint'(xb - xa);
   endfunction

   // Expected beat list: scan the clipped box group by group, test each pixel directly.
   function automatic void build_model();
      int bx0, bx1, by0, by1, x;
      longint e0, e1, e2;
      logic [LN-1:0] m;
      exp_q.delete();
      if (pt != 2'd2 && pt != 2'd3) return;
      bx0 = (px[0] < px[1]) ? px[0] : px[1];
      bx1 = (px[0] > px[1]) ? px[0] : px[1];
      by0 = (py[0] < py[1]) ? py[0] : py[1];
      by1 = (py[0] > py[1]) ? py[0] : py[1];
      if (pt == 2'd2) begin
         bx0 = (px[2] < bx0) ? px[2] : bx0;
         bx1 = (px[2] > bx1) ? px[2] : bx1;
         by0 = (py[2] < by0) ? py[2] : by0;
         by1 = (py[2] > by1) ? py[2] : by1;
         if (edge_v(px[0], py[0], px[1], py[1], px[2], py[2]) == 0) return;
      end
      bx0 = (cl[0] > bx0) ? cl[0] : bx0;
      by0 = (cl[1] > by0) ? cl[1] : by0;
      bx1 = (cl[2] < bx1) ? cl[2] : bx1;
      by1 = (cl[3] < by1) ? cl[3] : by1;
      if (bx0 > bx1 || by0 > by1) return;
      for (int y = by0; y <= by1; y++) begin
         for (int gx = bx0; gx <= bx1; gx += LN) begin
            m = '0;
            for (int l = 0; l < LN; l++) begin
               x = gx + l;
               if (x <= bx1) begin
                  if (pt == 2'd3) m[l] = 1'b1;
                  else begin
                     e0 = edge_v(px[0], py[0], px[1], py[1], x, y);
                     e1 = edge_v(px[1], py[1], px[2], py[2], x, y);
                     e2 = edge_v(px[2], py[2], px[0], py[0], x, y);
                     m[l] = (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
                  end
               end
            end
            if (m != '0) exp_q.push_back({CW'(gx), CW'(y), m});
         end
      end
   endfunction

   task automatic setp(input logic [1:0] t, input int x0, input int y0, input int x1, input int y1,
                       input int x2, input int y2, input int c0, input int c1, input int c2, input int c3);
      pt = t;
      px[0] = x0; py[0] = y0; px[1] = x1; py[1] = y1; px[2] = x2; py[2] = y2;
      cl[0] = c0; cl[1] = c1; cl[2] = c2; cl[3] = c3;
   endtask

   task automatic drive_prim();
      for (int i = 0; i < 20 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      chk("idle_ready", in_ready, 1'b1);
      in_type = pt;
      for (int i = 0; i < 3; i++) begin
         in_x[i*CW +: CW] = CW'(px[i]);
         in_y[i*CW +: CW] = CW'(py[i]);
      end
      clip_x0 = CW'(cl[0]); clip_y0 = CW'(cl[1]);
      clip_x1 = CW'(cl[2]); clip_y1 = CW'(cl[3]);
      in_trig = 1'b1;
      @(posedge clk); #1;
      in_trig = 1'b0;
   endtask

   // mode 0: always ready, 1: random ready, 2: stall the first beat for 3 cycles
   task automatic collect(input string tag, input int mode, input bit poke);
      int    stall;
      logic  pend, r;
      beat_t held;
      got_q.delete();
      first_idx = -1; done_seen = 1'b0; stall = 0; pend = 1'b0; held = '0;
      chk({tag, " busy"}, in_ready, 1'b0);
      for (int idx = 0; idx < 3000; idx++) begin
         if (pend) chk({tag, " hold"}, {out_trig, out_x, out_y, out_mask}, {1'b1, held});
         if (out_done) begin
            done_seen = 1'b1;
            break;
         end
         if (out_trig && first_idx < 0) first_idx = idx;
         if (mode == 0) r = 1'b1;
         else if (mode == 1) r = ($urandom_range(0, 3) != 0);
         else if (out_trig && got_q.size() == 0 && stall < 3) begin
            r = 1'b0;
            stall++;
         end else r = 1'b1;
         out_ready = r;
         if (out_trig && r) got_q.push_back({out_x, out_y, out_mask});
         pend = out_trig && !r;
         held = {out_x, out_y, out_mask};
         if (poke) begin
            in_trig = 1'($urandom_range(0, 1));
            in_x[CW-1:0] = CW'($urandom);
            in_type = 2'($urandom_range(0, 3));
         end
         @(posedge clk); #1;
      end
      in_trig = 1'b0;
      chk({tag, " done"}, done_seen, 1'b1);
      @(posedge clk); #1;
      chk({tag, " ready_back"}, in_ready, 1'b1);
      chk({tag, " count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s beat%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic run(input string tag, input int mode, input bit poke);
      build_model();
      drive_prim();
      collect(tag, mode, poke);
   endtask

   initial begin
      rst = 1'b1; in_trig = 1'b0; out_ready = 1'b1; in_type = '0;
      in_x = '0; in_y = '0; clip_x0 = '0; clip_y0 = '0; clip_x1 = '0; clip_y1 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", in_ready, 1'b1);
      chk("rst out_trig", out_trig, 1'b0);
      chk("rst out_done", out_done, 1'b0);
      chk("rst out_beat", {out_x, out_y, out_mask}, '0);
      rst = 1'b0;

      setp(2'd3, 2, 1, 5, 2, 0, 0, 0, 0, 100, 100);
      run("rect", 0, 1'b1);
      chk("rect latency", first_idx, 2);
      chk("rect beat0 const", got_q[0], {12'd2, 12'd1, 4'b1111});

      setp(2'd2, 0, 0, 3, 0, 0, 3, 0, 0, 100, 100);
      run("tri", 0, 1'b0);
      chk("tri latency", first_idx, 2);
      chk("tri beat1 const", got_q[1], {12'd0, 12'd1, 4'b0111});
      chk("tri beat3 const", got_q[3], {12'd0, 12'd3, 4'b0001});

      setp(2'd2, 0, 3, 3, 0, 0, 0, 0, 0, 100, 100);
      run("tri_rev", 0, 1'b0);
      setp(2'd2, 0, 0, 3, 0, 0, 3, 1, 1, 2, 2);
      run("tri_clip", 0, 1'b0);
      chk("tri_clip beat0 const", got_q[0], {12'd1, 12'd1, 4'b0011});
      setp(2'd2, 0, 0, 3, 0, 0, 3, 10, 10, 20, 20);
      run("tri_clip_out", 0, 1'b0);
      setp(2'd2, 0, 0, 2, 2, 4, 4, 0, 0, 100, 100);
      run("tri_degen", 0, 1'b0);
      setp(2'd1, 0, 0, 5, 5, 0, 0, 0, 0, 100, 100);
      run("line", 0, 1'b0);
      setp(2'd3, 7, 7, 7, 7, 0, 0, 0, 0, 100, 100);
      run("pixel", 0, 1'b0);
      chk("pixel mask const", got_q[0], {12'd7, 12'd7, 4'b0001});
      setp(2'd3, 0, 0, 7, 0, 0, 0, 0, 0, 100, 100);
      run("stall", 2, 1'b0);

      setp(2'd3, 0, 0, 15, 15, 0, 0, 0, 0, 100, 100);
      drive_prim();
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst out_trig", out_trig, 1'b0);
      chk("midrst in_ready", in_ready, 1'b1);
      chk("midrst out_done", out_done, 1'b0);
      rst = 1'b0;
      setp(2'd3, -3, -2, 6, 1, 0, 0, -100, -100, 100, 100);
      run("after_rst", 1, 1'b0);

      for (int k = 0; k < 50; k++) begin
         int big;
         big = ($urandom_range(0, 3) == 0) ? 1 : 0;
         pt = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) != 0) pt = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd3;
         for (int i = 0; i < 3; i++) begin
            px[i] = big ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 32)) - 16;
            py[i] = big ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 32)) - 16;
         end
         if (big != 0) begin
            cl[0] = int'($urandom_range(0, 4000)) - 2048;
            cl[1] = int'($urandom_range(0, 4000)) - 2048;
            cl[2] = cl[0] + int'($urandom_range(0, 10));
            cl[3] = cl[1] + int'($urandom_range(0, 10));
         end else begin
            cl[0] = int'($urandom_range(0, 30)) - 20;
            cl[1] = int'($urandom_range(0, 30)) - 20;
            cl[2] = cl[0] + int'($urandom_range(0, 30)) - 3;
            cl[3] = cl[1] + int'($urandom_range(0, 30)) - 3;
         end
         run($sformatf("rnd%0d", k), 1, 1'(k % 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
